// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-side byte handshake for the UART transmit arbiter.
// "slave" is the arbiter's view; "master" is the surrounding environment.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_data, out_valid
  );

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_data, out_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel; a grant is held for a
// whole message (until req_last) with a watchdog that releases a stalled owner.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            timeout_err,
  output logic [IDW-1:0]  timeout_id
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Release fires on the edge that would take the count to TIMEOUT.
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0] RR_INIT = IDW'(NREQ - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] tid_nxt;
  logic [WDW-1:0] wdog, wdog_nxt;
  logic           terr_nxt;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           any_req;
  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;

  // Scan downward so the candidate nearest rr_ptr+1 is the one left standing.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid = bus.req_valid[owner];
    own_last  = bus.req_last[owner];
    own_data  = bus.req_data[8*int'(owner) +: 8];
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    wdog_nxt      = wdog;
    terr_nxt      = 1'b0;
    tid_nxt       = timeout_id;
    grant         = '0;
    busy          = 1'b0;
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = XFER;
          owner_nxt = winner;
          wdog_nxt  = '0;
        end
      end
      XFER: begin
        grant[owner]         = 1'b1;
        busy                 = 1'b1;
        bus.out_valid        = own_valid;
        bus.out_data         = own_data;
        bus.req_ready[owner] = bus.out_ready;
        if (own_valid) begin
          // Backpressure from the TX side never counts toward the watchdog.
          wdog_nxt = '0;
          if (bus.out_ready && own_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner;
          end
        end else if (TIMEOUT > 0) begin
          if (wdog == WD_LAST) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner;
            terr_nxt   = 1'b1;
            tid_nxt    = owner;
            wdog_nxt   = '0;
          end else begin
            wdog_nxt = wdog + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= RR_INIT;
      wdog        <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= terr_nxt;
      timeout_id  <= tid_nxt;
    end
  end

endmodule
